// File: rtl/stage_complete_pkg.sv
// Shared definitions for the complete stage: result packet layout, FU source ids, widths.
package stage_complete_pkg;

  localparam int unsigned NUM_SRC    = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned PREG_IDX_W = 6;
  localparam int unsigned ROB_IDX_W  = 5;
  localparam int unsigned SRC_IDX_W  = $clog2(NUM_SRC);

  typedef enum logic [SRC_IDX_W-1:0] {
    FU_ALU,
    FU_MULT,
    FU_LOAD,
    FU_STORE,
    FU_BRANCH
  } fu_src_e;

  typedef struct packed {
    logic [XLEN-1:0]       value;
    logic [PREG_IDX_W-1:0] dest_preg;
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic                  take_branch;
    logic [XLEN-1:0]       target;
    logic                  halt;
  } CO_PKT;

endpackage

// File: rtl/stage_complete_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, scanning circularly.
module rr_arbiter #(
  parameter int unsigned N = 5,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin : arb
    int unsigned k;
    k     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      k = (32'(ptr) + off) % N;
      if (!valid && req[k[W-1:0]]) begin
        valid           = 1'b1;
        idx             = k[W-1:0];
        grant[k[W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stage_complete.sv
// Complete stage: one result slot per FU class, round-robin drained onto the CDB / ROB port.
module stage_complete
  import stage_complete_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [NUM_SRC-1:0]        fu_done,
  input  CO_PKT [NUM_SRC-1:0]       fu_result,
  output logic [NUM_SRC-1:0]        fu_ack,
  output logic                      cdb_valid,
  output logic                      cdb_tag_valid,
  output logic [PREG_IDX_W-1:0]     cdb_tag,
  output logic [XLEN-1:0]           cdb_value,
  output logic                      rob_complete,
  output logic [ROB_IDX_W-1:0]      rob_idx,
  output logic                      rob_take_br,
  output logic [XLEN-1:0]           rob_target,
  output logic                      rob_halt
);

  logic [NUM_SRC-1:0]   r_slot_v;
  CO_PKT [NUM_SRC-1:0]  r_slot;
  logic [SRC_IDX_W-1:0] r_rr_ptr;

  logic [NUM_SRC-1:0]   w_grant;
  logic [SRC_IDX_W-1:0] w_gidx;
  logic                 w_gvalid;
  CO_PKT                w_sel;

  // Arbitration sees only registered slot state, so no input reaches the CDB in the same cycle.
  rr_arbiter #(
    .N (NUM_SRC),
    .W (SRC_IDX_W)
  ) u_arb (
    .req   (r_slot_v),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_gidx),
    .valid (w_gvalid)
  );

  assign fu_ack = (reset || squash) ? '0 : (fu_done & (~r_slot_v | w_grant));

  assign w_sel         = w_gvalid ? r_slot[w_gidx] : '0;
  assign cdb_valid     = w_gvalid && !squash;
  assign rob_complete  = cdb_valid;
  assign cdb_tag_valid = cdb_valid && (w_sel.dest_preg != '0);
  assign cdb_tag       = w_sel.dest_preg;
  assign cdb_value     = w_sel.value;
  assign rob_idx       = w_sel.rob_idx;
  assign rob_take_br   = w_sel.take_branch;
  assign rob_target    = w_sel.target;
  assign rob_halt      = w_sel.halt;

  // Granted slot drains; a simultaneous ack refills it in the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slot_v <= '0;
      r_rr_ptr <= '0;
    end else if (squash) begin
      r_slot_v <= '0;
    end else begin
      r_slot_v <= (r_slot_v & ~w_grant) | fu_ack;
      if (w_gvalid)
        r_rr_ptr <= (w_gidx == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slot <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++)
        if (fu_ack[i]) r_slot[i] <= fu_result[i];
    end
  end

endmodule

// File: tb/tb_stage_complete.sv
// Bench for stage_complete: per-cycle reference model compare plus directed literal scenarios.
module tb_stage_complete;
  import stage_complete_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  squash;
  logic [NUM_SRC-1:0]    fu_done;
  CO_PKT [NUM_SRC-1:0]   fu_result;
  logic [NUM_SRC-1:0]    fu_ack;
  logic                  cdb_valid, cdb_tag_valid, rob_complete, rob_take_br, rob_halt;
  logic [PREG_IDX_W-1:0] cdb_tag;
  logic [XLEN-1:0]       cdb_value, rob_target;
  logic [ROB_IDX_W-1:0]  rob_idx;

  int checks = 0;
  int errors = 0;

  stage_complete dut (
    .clock(clock), .reset(reset), .squash(squash), .fu_done(fu_done), .fu_result(fu_result),
    .fu_ack(fu_ack), .cdb_valid(cdb_valid), .cdb_tag_valid(cdb_tag_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .rob_complete(rob_complete), .rob_idx(rob_idx),
    .rob_take_br(rob_take_br), .rob_target(rob_target), .rob_halt(rob_halt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic CO_PKT mk(input int unsigned v, input int unsigned dst, input int unsigned rob,
                               input bit tb, input int unsigned tgt, input bit h);
    CO_PKT p;
    p.value       = XLEN'(v);
    p.dest_preg   = PREG_IDX_W'(dst);
    p.rob_idx     = ROB_IDX_W'(rob);
    p.take_branch = tb;
    p.target      = XLEN'(tgt);
    p.halt        = h;
    return p;
  endfunction

  // Reference model: pending result per source, a round-robin start index.
  bit    mv[NUM_SRC];
  CO_PKT ms[NUM_SRC];
  int    mptr = 0;

  always @(negedge clock) begin : cmp
    int                 g;
    int                 s;
    CO_PKT              e;
    logic               ev;
    logic [NUM_SRC-1:0] eack;
    g = -1;
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) mv[i] = 1'b0;
      mptr = 0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        s = (mptr + k) % NUM_SRC;
        if (g < 0 && mv[s]) g = s;
      end
    end
    e    = (g >= 0) ? ms[g] : '0;
    ev   = (g >= 0) && !squash && !reset;
    eack = '0;
    if (!reset && !squash)
      for (int i = 0; i < NUM_SRC; i++) eack[i] = fu_done[i] && (!mv[i] || g == i);
    check("m_ack",     64'(fu_ack),        64'(eack));
    check("m_valid",   64'(cdb_valid),     64'(ev));
    check("m_robc",    64'(rob_complete),  64'(ev));
    check("m_tagv",    64'(cdb_tag_valid), 64'(ev && e.dest_preg != 0));
    check("m_tag",     64'(cdb_tag),       64'(e.dest_preg));
    check("m_value",   64'(cdb_value),     64'(e.value));
    check("m_robidx",  64'(rob_idx),       64'(e.rob_idx));
    check("m_takebr",  64'(rob_take_br),   64'(e.take_branch));
    check("m_target",  64'(rob_target),    64'(e.target));
    check("m_halt",    64'(rob_halt),      64'(e.halt));
    if (!reset) begin
      if (squash) begin
        for (int i = 0; i < NUM_SRC; i++) mv[i] = 1'b0;
      end else begin
        if (g >= 0) begin
          mv[g] = 1'b0;
          mptr  = (g + 1) % NUM_SRC;
        end
        for (int i = 0; i < NUM_SRC; i++)
          if (eack[i]) begin
            mv[i] = 1'b1;
            ms[i] = fu_result[i];
          end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rst_pulse();
    step();
    reset = 1'b1;
    fu_done = '0;
    squash = 1'b0;
    step();
    reset = 1'b0;
  endtask

  int nres[NUM_SRC];
  int nbc[NUM_SRC];
  int src;

  initial begin
    reset = 1'b1; squash = 1'b0; fu_done = '0; fu_result = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Single ALU result, one-cycle latency
    fu_done = 5'b00001;
    fu_result[FU_ALU] = mk(13, 7, 3, 0, 0, 0);
    @(negedge clock);
    check("t2_ack", 64'(fu_ack), 64'h1);
    check("t2_early", 64'(cdb_valid), 64'h0);
    step(); fu_done = '0;
    @(negedge clock);
    check("t2_valid", 64'(cdb_valid), 64'h1);
    check("t2_tag",   64'(cdb_tag),   64'd7);
    check("t2_value", 64'(cdb_value), 64'd13);
    check("t2_rob",   64'(rob_idx),   64'd3);
    step();
    @(negedge clock);
    check("t2_after", 64'(cdb_valid), 64'h0);

    // ALU + MULT together from pointer 0, then pointer must sit at LOAD
    rst_pulse();
    fu_done = 5'b00011;
    fu_result[FU_ALU]  = mk(11, 4, 1, 0, 0, 0);
    fu_result[FU_MULT] = mk(18, 3, 2, 0, 0, 0);
    @(negedge clock);
    check("t3_ack", 64'(fu_ack), 64'h3);
    step(); fu_done = '0;
    @(negedge clock);
    check("t3_first",  64'(cdb_value), 64'd11);
    check("t3_ftag",   64'(cdb_tag),   64'd4);
    step();
    @(negedge clock);
    check("t3_second", 64'(cdb_value), 64'd18);
    check("t3_stag",   64'(cdb_tag),   64'd3);
    step();
    fu_done = 5'b00101;
    fu_result[FU_ALU]  = mk(21, 1, 4, 0, 0, 0);
    fu_result[FU_LOAD] = mk(22, 2, 5, 0, 0, 0);
    step(); fu_done = '0;
    @(negedge clock);
    check("t3_ptr_load", 64'(cdb_value), 64'd22);
    step();
    @(negedge clock);
    check("t3_ptr_alu", 64'(cdb_value), 64'd21);
    step();

    // Store without destination, then a taken branch
    fu_done = 5'b01000;
    fu_result[FU_STORE] = mk(32'h55, 0, 9, 0, 0, 0);
    step(); fu_done = '0;
    @(negedge clock);
    check("t6_st_valid", 64'(cdb_valid),     64'h1);
    check("t6_st_tagv",  64'(cdb_tag_valid), 64'h0);
    check("t6_st_rob",   64'(rob_idx),       64'd9);
    step();
    fu_done = 5'b10000;
    fu_result[FU_BRANCH] = mk(32'h77, 5, 10, 1, 32'h40, 0);
    step(); fu_done = '0;
    @(negedge clock);
    check("t6_br_take", 64'(rob_take_br),   64'h1);
    check("t6_br_tgt",  64'(rob_target),    64'h40);
    check("t6_br_tag",  64'(cdb_tag),       64'd5);
    check("t6_br_tagv", 64'(cdb_tag_valid), 64'h1);
    step();

    // Squash with slots 1,2,4 occupied
    fu_done = 5'b10110;
    fu_result[FU_MULT]   = mk(101, 11, 11, 0, 0, 0);
    fu_result[FU_LOAD]   = mk(102, 12, 12, 0, 0, 0);
    fu_result[FU_BRANCH] = mk(104, 14, 14, 0, 0, 1);
    step();
    fu_done = 5'b00001; squash = 1'b1;
    fu_result[FU_ALU] = mk(100, 10, 10, 0, 0, 0);
    @(negedge clock);
    check("t5_sq_valid", 64'(cdb_valid), 64'h0);
    check("t5_sq_ack",   64'(fu_ack),    64'h0);
    step(); fu_done = '0; squash = 1'b0;
    @(negedge clock);
    check("t5_empty1", 64'(cdb_valid), 64'h0);
    step();
    @(negedge clock);
    check("t5_empty2", 64'(cdb_valid), 64'h0);

    // Reset with slots 0,1,4 full
    step();
    fu_done = 5'b10011;
    fu_result[FU_ALU]    = mk(201, 21, 1, 1, 32'h80, 1);
    fu_result[FU_MULT]   = mk(202, 22, 2, 0, 0, 0);
    fu_result[FU_BRANCH] = mk(204, 24, 4, 1, 32'h90, 1);
    step();
    fu_done = 5'b00001; reset = 1'b1;
    #1;
    check("t1_valid", 64'(cdb_valid),    64'h0);
    check("t1_robc",  64'(rob_complete), 64'h0);
    check("t1_value", 64'(cdb_value),    64'h0);
    check("t1_tgt",   64'(rob_target),   64'h0);
    check("t1_ack",   64'(fu_ack),       64'h0);
    step(); reset = 1'b0; fu_done = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t1_quiet", 64'(cdb_valid), 64'h0);
      step();
    end
    fu_done = 5'b00010;
    fu_result[FU_MULT] = mk(303, 30, 3, 0, 0, 0);
    step(); fu_done = '0;
    @(negedge clock);
    check("t1_new", 64'(cdb_value), 64'd303);

    // All sources busy for 20 broadcasts: strict rotation, stalled FUs see no ack
    rst_pulse();
    for (int s = 0; s < NUM_SRC; s++) begin nres[s] = 0; nbc[s] = 0; end
    for (int k = 0; k <= 20; k++) begin
      fu_done = '1;
      for (int s = 0; s < NUM_SRC; s++)
        fu_result[s] = mk(s * 100 + nres[s], s + 1, s, 0, 0, 0);
      @(negedge clock);
      if (k == 0) begin
        check("t4_ack0", 64'(fu_ack), 64'h1f);
      end else begin
        src = (k - 1) % NUM_SRC;
        check("t4_valid", 64'(cdb_valid), 64'h1);
        check("t4_value", 64'(cdb_value), 64'(src * 100 + nbc[src]));
        check("t4_ack",   64'(fu_ack),    64'(1 << src));
        nbc[src]++;
      end
      for (int s = 0; s < NUM_SRC; s++) if (fu_ack[s]) nres[s]++;
      step();
    end
    fu_done = '0;
    repeat (6) step();

    // Random traffic with occasional squash and reset
    for (int k = 0; k < 600; k++) begin
      reset   = ($urandom_range(0, 99) == 0);
      squash  = ($urandom_range(0, 15) == 0);
      fu_done = NUM_SRC'($urandom);
      for (int s = 0; s < NUM_SRC; s++)
        fu_result[s] = mk($urandom, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63),
                          $urandom, 1'($urandom), $urandom, 1'($urandom));
      step();
    end
    reset = 1'b0; squash = 1'b0; fu_done = '0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
